// File: rtl/counter_pkg.sv
// Shared types and constants for the parameterised up/down counter.
package counter_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/up_down_counter_param_if.sv
// Control/status bundle of the up/down counter; master drives controls, slave is the counter.
interface up_down_counter_param_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             up_down;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             clr_flags;
    logic [WIDTH-1:0] count;
    logic             wrap_pulse;
    logic             at_max;
    logic             at_min;
    logic             ovf_sticky;
    logic             unf_sticky;

    modport master (
        output en, up_down, load, load_val, clr_flags,
        input  count, wrap_pulse, at_max, at_min, ovf_sticky, unf_sticky
    );

    modport slave (
        input  en, up_down, load, load_val, clr_flags,
        output count, wrap_pulse, at_max, at_min, ovf_sticky, unf_sticky
    );
endinterface

// File: rtl/tick_prescaler.sv
// Emits tick on every PRESCALE-th enabled cycle; collapses to tick = en when PRESCALE is 1.
module tick_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    generate
        if (PRESCALE == 1) begin : g_bypass
            logic unused_ports;
            assign unused_ports = ^{clk, reset_n, clr};
            assign tick         = en;
        end else begin : g_div
            localparam int unsigned CW = $clog2(PRESCALE);
            localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

            logic [CW-1:0] cnt;

            assign tick = en && (cnt == LAST);

            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt <= '0;
                end else if (clr) begin
                    cnt <= '0;
                end else if (en) begin
                    cnt <= tick ? '0 : cnt + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/up_down_counter_param.sv
// Parameterised up/down counter with load, wrap or saturate boundaries, and sticky flags.
module up_down_counter_param
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH    = 4,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter cnt_mode_e        MODE     = CNT_WRAP,
    parameter int unsigned      PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             wrap_pulse,
    output logic             at_max,
    output logic             at_min,
    output logic             ovf_sticky,
    output logic             unf_sticky
);

    logic             tick;
    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;
    logic             ovf_set;
    logic             unf_set;

    // Load restarts the step interval so the next step needs a full PRESCALE.
    tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .clr     (load),
        .tick    (tick)
    );

    assign at_max = (count == MAX_VAL);
    assign at_min = (count == '0);

    // NOTE: every output gets a default first, so no path can infer a latch.
    always_comb begin
        count_nxt = count;
        wrap_nxt  = 1'b0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        if (load) begin
            count_nxt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (tick) begin
            if (up_down == DIR_UP) begin
                if (at_max) begin
                    ovf_set = 1'b1;
                    if (MODE == CNT_WRAP) begin
                        count_nxt = '0;
                        wrap_nxt  = 1'b1;
                    end
                end else begin
                    count_nxt = count + 1'b1;
                end
            end else begin
                if (at_min) begin
                    unf_set = 1'b1;
                    if (MODE == CNT_WRAP) begin
                        count_nxt = MAX_VAL;
                        wrap_nxt  = 1'b1;
                    end
                end else begin
                    count_nxt = count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count      <= '0;
            wrap_pulse <= 1'b0;
            ovf_sticky <= 1'b0;
            unf_sticky <= 1'b0;
        end else begin
            count      <= count_nxt;
            wrap_pulse <= wrap_nxt;
            // A set in the same cycle as clr_flags wins.
            ovf_sticky <= ovf_set | (ovf_sticky & ~clr_flags);
            unf_sticky <= unf_set | (unf_sticky & ~clr_flags);
        end
    end

endmodule

// File: tb/tb_up_down_counter_param.sv
// Scoreboard bench for up_down_counter_param across wrap, saturate, prescaled and 32-bit configurations.
module tb_up_down_counter_param;
    import counter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    up_down_counter_param_if #(.WIDTH(4))  bw ();
    up_down_counter_param_if #(.WIDTH(4))  bs ();
    up_down_counter_param_if #(.WIDTH(4))  bp ();
    up_down_counter_param_if #(.WIDTH(32)) bx ();

    up_down_counter_param #(.WIDTH(4), .MAX_VAL(4'd9), .MODE(CNT_WRAP), .PRESCALE(1)) dut_wrap (
        .clk(clk), .reset_n(rst_n), .en(bw.en), .up_down(bw.up_down), .load(bw.load),
        .load_val(bw.load_val), .clr_flags(bw.clr_flags), .count(bw.count),
        .wrap_pulse(bw.wrap_pulse), .at_max(bw.at_max), .at_min(bw.at_min),
        .ovf_sticky(bw.ovf_sticky), .unf_sticky(bw.unf_sticky));

    up_down_counter_param #(.WIDTH(4), .MAX_VAL(4'd9), .MODE(CNT_SAT), .PRESCALE(1)) dut_sat (
        .clk(clk), .reset_n(rst_n), .en(bs.en), .up_down(bs.up_down), .load(bs.load),
        .load_val(bs.load_val), .clr_flags(bs.clr_flags), .count(bs.count),
        .wrap_pulse(bs.wrap_pulse), .at_max(bs.at_max), .at_min(bs.at_min),
        .ovf_sticky(bs.ovf_sticky), .unf_sticky(bs.unf_sticky));

    up_down_counter_param #(.WIDTH(4), .MAX_VAL(4'd9), .MODE(CNT_WRAP), .PRESCALE(3)) dut_pre (
        .clk(clk), .reset_n(rst_n), .en(bp.en), .up_down(bp.up_down), .load(bp.load),
        .load_val(bp.load_val), .clr_flags(bp.clr_flags), .count(bp.count),
        .wrap_pulse(bp.wrap_pulse), .at_max(bp.at_max), .at_min(bp.at_min),
        .ovf_sticky(bp.ovf_sticky), .unf_sticky(bp.unf_sticky));

    up_down_counter_param #(.WIDTH(32), .MODE(CNT_WRAP), .PRESCALE(1)) dut_w32 (
        .clk(clk), .reset_n(rst_n), .en(bx.en), .up_down(bx.up_down), .load(bx.load),
        .load_val(bx.load_val), .clr_flags(bx.clr_flags), .count(bx.count),
        .wrap_pulse(bx.wrap_pulse), .at_max(bx.at_max), .at_min(bx.at_min),
        .ovf_sticky(bx.ovf_sticky), .unf_sticky(bx.unf_sticky));

    // Per-instance configuration and reference model state, indexed 0..3 as instantiated above.
    logic [31:0] maxv [4] = '{32'd9, 32'd9, 32'd9, 32'hFFFF_FFFF};
    cnt_mode_e   mode [4] = '{CNT_WRAP, CNT_SAT, CNT_WRAP, CNT_WRAP};
    int          pres [4] = '{1, 1, 3, 1};

    logic [31:0] m_cnt [4];
    logic        m_ovf [4];
    logic        m_unf [4];
    int          m_pre [4];

    typedef struct {
        string       tag;
        int          id;
        logic [36:0] v;   // {count, wrap_pulse, ovf, unf, at_max, at_min}
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [36:0] obs, input logic [36:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed cnt=%h flags=%b expected cnt=%h flags=%b",
                   tag, obs[36:5], obs[4:0], exp[36:5], exp[4:0]);
        end
    endtask

    function automatic logic [36:0] observe(input int id);
        case (id)
            0:       return {32'(bw.count), bw.wrap_pulse, bw.ovf_sticky, bw.unf_sticky, bw.at_max, bw.at_min};
            1:       return {32'(bs.count), bs.wrap_pulse, bs.ovf_sticky, bs.unf_sticky, bs.at_max, bs.at_min};
            2:       return {32'(bp.count), bp.wrap_pulse, bp.ovf_sticky, bp.unf_sticky, bp.at_max, bp.at_min};
            default: return {bx.count, bx.wrap_pulse, bx.ovf_sticky, bx.unf_sticky, bx.at_max, bx.at_min};
        endcase
    endfunction

    function automatic logic [36:0] model_out(input int id, input logic wrap);
        return {m_cnt[id], wrap, m_ovf[id], m_unf[id], m_cnt[id] == maxv[id], m_cnt[id] == 32'd0};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = '0;
            m_ovf[i] = 1'b0;
            m_unf[i] = 1'b0;
            m_pre[i] = 0;
        end
    endtask

    task automatic idle_all();
        bw.en = 0; bw.up_down = 0; bw.load = 0; bw.load_val = '0; bw.clr_flags = 0;
        bs.en = 0; bs.up_down = 0; bs.load = 0; bs.load_val = '0; bs.clr_flags = 0;
        bp.en = 0; bp.up_down = 0; bp.load = 0; bp.load_val = '0; bp.clr_flags = 0;
        bx.en = 0; bx.up_down = 0; bx.load = 0; bx.load_val = '0; bx.clr_flags = 0;
    endtask

    // Drive one cycle on instance id, predict its response, and check it after the edge.
    task automatic step(input int id, input logic en, input logic ud, input logic ld,
                        input logic [31:0] lv, input logic clr, input string tag);
        logic tick;
        logic wrap;
        logic ovf_set;
        logic unf_set;
        exp_t e;
        idle_all();
        case (id)
            0:       begin bw.en = en; bw.up_down = ud; bw.load = ld; bw.load_val = lv[3:0]; bw.clr_flags = clr; end
            1:       begin bs.en = en; bs.up_down = ud; bs.load = ld; bs.load_val = lv[3:0]; bs.clr_flags = clr; end
            2:       begin bp.en = en; bp.up_down = ud; bp.load = ld; bp.load_val = lv[3:0]; bp.clr_flags = clr; end
            default: begin bx.en = en; bx.up_down = ud; bx.load = ld; bx.load_val = lv;      bx.clr_flags = clr; end
        endcase
        if (id < 3) lv = lv & 32'hF;

        tick = en && (m_pre[id] == pres[id] - 1);
        if (ld) m_pre[id] = 0;
        else if (en) m_pre[id] = tick ? 0 : m_pre[id] + 1;

        wrap = 1'b0; ovf_set = 1'b0; unf_set = 1'b0;
        if (ld) begin
            m_cnt[id] = (lv > maxv[id]) ? maxv[id] : lv;
        end else if (tick && ud == DIR_UP) begin
            if (m_cnt[id] == maxv[id]) begin
                ovf_set = 1'b1;
                if (mode[id] == CNT_WRAP) begin m_cnt[id] = 0; wrap = 1'b1; end
            end else m_cnt[id] = m_cnt[id] + 1;
        end else if (tick) begin
            if (m_cnt[id] == 0) begin
                unf_set = 1'b1;
                if (mode[id] == CNT_WRAP) begin m_cnt[id] = maxv[id]; wrap = 1'b1; end
            end else m_cnt[id] = m_cnt[id] - 1;
        end
        m_ovf[id] = ovf_set | (m_ovf[id] & ~clr);
        m_unf[id] = unf_set | (m_unf[id] & ~clr);

        sb.push_back('{tag: tag, id: id, v: model_out(id, wrap)});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check(e.tag, observe(e.id), e.v);
    endtask

    initial begin
        idle_all();
        model_reset();
        #12;
        for (int i = 0; i < 4; i++) check($sformatf("reset_state_%0d", i), observe(i), model_out(i, 1'b0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Wrap mode: count up through MAX_VAL and back to 0, then reverse direction.
        for (int i = 0; i < 11; i++) step(0, 1, DIR_UP, 0, 0, 0, $sformatf("wrap_up_%0d", i));
        step(0, 1, DIR_DOWN, 0, 0, 0, "wrap_dir_change");
        step(0, 1, DIR_DOWN, 0, 0, 0, "wrap_down_at_zero");
        step(0, 1, DIR_DOWN, 0, 0, 0, "wrap_down_8");
        step(0, 0, DIR_DOWN, 0, 0, 1, "wrap_clr_flags");
        step(0, 0, DIR_UP,   1, 15, 0, "wrap_load_clamp");
        step(0, 1, DIR_UP,   1, 3, 0, "wrap_load_beats_step");

        // Saturate mode: hold at both boundaries; set beats clr_flags.
        step(1, 1, DIR_DOWN, 0, 0, 0, "sat_down_at_zero");
        for (int i = 0; i < 12; i++) step(1, 1, DIR_UP, 0, 0, 0, $sformatf("sat_up_%0d", i));
        step(1, 1, DIR_UP, 0, 0, 1, "sat_clr_vs_ovf_set");

        // Prescale 3: enable pattern 1,1,0,1 gives one step, then load on a tick.
        step(2, 1, DIR_UP, 0, 0, 0, "pre_en1");
        step(2, 1, DIR_UP, 0, 0, 0, "pre_en2");
        step(2, 0, DIR_UP, 0, 0, 0, "pre_hold");
        step(2, 1, DIR_UP, 0, 0, 0, "pre_tick");
        step(2, 1, DIR_UP, 0, 0, 0, "pre_a1");
        step(2, 1, DIR_UP, 0, 0, 0, "pre_a2");
        step(2, 1, DIR_UP, 1, 5, 0, "pre_load_on_tick");
        step(2, 1, DIR_UP, 0, 0, 0, "pre_b1");
        step(2, 1, DIR_UP, 0, 0, 0, "pre_b2");
        step(2, 1, DIR_UP, 0, 0, 0, "pre_b3");
        step(2, 1, DIR_UP, 0, 0, 0, "pre_c1");
        step(2, 1, DIR_UP, 0, 0, 0, "pre_c2");

        // Asynchronous reset between edges, with a load pending on the wrap instance.
        bw.load = 1'b1;
        bw.load_val = 4'd7;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 4; i++) check($sformatf("async_reset_%0d", i), observe(i), model_out(i, 1'b0));
        idle_all();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(2, 1, DIR_UP, 0, 0, 0, "post_rst_en1");
        step(2, 1, DIR_UP, 0, 0, 0, "post_rst_en2");
        step(2, 1, DIR_UP, 0, 0, 0, "post_rst_en3");
        step(0, 1, DIR_UP, 0, 0, 0, "post_rst_wrap_up");

        // 32-bit full-range boundaries.
        step(3, 0, DIR_UP,   1, 32'hFFFF_FFFE, 0, "w32_load");
        step(3, 1, DIR_UP,   0, 0, 0, "w32_to_max");
        step(3, 1, DIR_UP,   0, 0, 0, "w32_wrap_up");
        step(3, 1, DIR_DOWN, 0, 0, 0, "w32_wrap_down");
        step(3, 0, DIR_DOWN, 0, 0, 1, "w32_clr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/up_down_counter_param.md
UP_DOWN_COUNTER_PARAM -- requirements
Module: up_down_counter_param

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter width in bits, legal range 2..32.
REQ-002 SHALL have parameter MAX_VAL, default 2**WIDTH-1: highest count value, legal range 1..2**WIDTH-1.
REQ-003 SHALL have parameter MODE, default CNT_WRAP: boundary behaviour, either CNT_WRAP or CNT_SAT.
REQ-004 SHALL have parameter PRESCALE, default 1: enabled cycles per count step, legal range 1..65535.
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port en, input, 1: count enable; gates the prescaler.
REQ-008 SHALL have port up_down, input, 1: direction; 0 = up, 1 = down.
REQ-009 SHALL have port load, input, 1: synchronous load strobe.
REQ-010 SHALL have port load_val, input, WIDTH: value written on load.
REQ-011 SHALL have port clr_flags, input, 1: clears the sticky flags.
REQ-012 SHALL have port count, output, WIDTH: registered count value.
REQ-013 SHALL have port wrap_pulse, output, 1: registered one-cycle pulse on a wrap.
REQ-014 SHALL have port at_max, output, 1: combinational, asserted when count == MAX_VAL.
REQ-015 SHALL have port at_min, output, 1: combinational, asserted when count == 0.
REQ-016 SHALL have port ovf_sticky, output, 1: set by an up step attempted at MAX_VAL.
REQ-017 SHALL have port unf_sticky, output, 1: set by a down step attempted at 0.

Function
REQ-018 A step SHALL occur in a cycle where en=1 and the prescaler tick is high; the tick SHALL be high on every PRESCALE-th enabled cycle, and on every enabled cycle when PRESCALE=1.
REQ-019 The prescaler SHALL hold its value while en=0 and SHALL be cleared to 0 by load.
REQ-020 count SHALL update on the clock edge that samples the step or load (1-cycle latency).
REQ-021 load SHALL take priority over a step: count <= min(load_val, MAX_VAL), no flag or pulse is generated, and the step in that cycle is discarded.
REQ-022 Up step with count < MAX_VAL SHALL give count+1; down step with count > 0 SHALL give count-1.
REQ-023 Up step at MAX_VAL: in CNT_WRAP, count SHALL become 0 and wrap_pulse SHALL be 1 for the next cycle; in CNT_SAT, count SHALL hold. In both modes ovf_sticky SHALL be set.
REQ-024 Down step at 0: in CNT_WRAP, count SHALL become MAX_VAL and wrap_pulse SHALL be 1 for the next cycle; in CNT_SAT, count SHALL hold. In both modes unf_sticky SHALL be set.
REQ-025 wrap_pulse SHALL be 0 in all other cycles, including in CNT_SAT.
REQ-026 A change of up_down SHALL take effect at the next step, with no extra latency.
REQ-027 clr_flags SHALL clear both sticky flags next cycle; if a set condition occurs in the same cycle, the set SHALL win.
REQ-028 All arithmetic SHALL be WIDTH bits, with no intermediate overflow at WIDTH=32, MAX_VAL=2**32-1.

Reset
REQ-029 On reset_n=0, immediately and regardless of clk: count=0, wrap_pulse=0, ovf_sticky=0, unf_sticky=0, prescaler=0.
REQ-030 Reset asserted mid-operation (including during load or at a boundary) SHALL abandon the operation; the first step after deassertion SHALL require a full PRESCALE enabled cycles.

Structure
REQ-031 Package counter_pkg SHALL hold the mode type (CNT_WRAP, CNT_SAT) and the direction constants DIR_UP=0 and DIR_DOWN=1.
REQ-032 The prescaler SHALL be sub-module tick_prescaler (parameter PRESCALE; inputs clk, reset_n, en, clr; output tick); when PRESCALE=1 it SHALL reduce to tick=en.

Verification
REQ-033 WIDTH=4, MAX_VAL=9, CNT_WRAP, PRESCALE=1, en=1, up -> count 0..9 then 0; wrap_pulse high exactly the cycle count shows 0; ovf_sticky=1.
REQ-034 Same configuration, down from 0 -> count 9, 8, ...; wrap_pulse once; unf_sticky=1; clr_flags -> both stickies 0.
REQ-035 CNT_SAT, MAX_VAL=9, up 12 steps -> count holds at 9, at_max=1, wrap_pulse never high, ovf_sticky=1.
REQ-036 PRESCALE=3, en toggling 1,1,0,1 -> exactly one step, after the 3rd enabled cycle; load in the same cycle as a tick -> loaded value, no step.
REQ-037 load_val=15 with MAX_VAL=9 -> count=9; reset_n pulse mid-count -> count=0 immediately, independent of clk.
REQ-038 clr_flags in the same cycle as an up step at MAX_VAL -> ovf_sticky remains 1.
